// File: rtl/cache_pkg.sv
// Shared types and geometry for the L1 data cache: FSM state encoding,
// derived index/tag widths and the per-line record exposed by the storage array.
package cache_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int NUM_SETS = 256;
  localparam int INDEX_W  = $clog2(NUM_SETS);
  localparam int TAG_W    = ADDR_W - 2 - INDEX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } line_t;

endpackage

// File: rtl/cache_data_array.sv
// Tag/data storage for the direct-mapped cache: one word per line, a
// combinational read port and a single write port that either installs a
// whole line (fill) or merges enabled bytes into an existing line.
// Only the valid bits are reset; tag and data contents are left as-is.
module cache_data_array
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_idx,
  output line_t              rd_line,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic               wr_fill,
  input  logic               wr_merge,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [DATA_W/8-1:0] wr_be
);

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  logic [DATA_W-1:0]   data_mem [NUM_SETS];

  assign rd_line.valid = valid_q[rd_idx];
  assign rd_line.tag   = tag_mem[rd_idx];
  assign rd_line.data  = data_mem[rd_idx];

  // Valid bits: cleared asynchronously by reset, set when a line is filled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_fill) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag/data storage: fill replaces the line, merge updates only enabled bytes
  always_ff @(posedge clk) begin
    if (wr_fill) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end else if (wr_merge) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wr_be[b]) begin
          data_mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache controller.
// Loads that hit return data in the same cycle; read misses fill one line
// from memory, and every store is written through to memory (merging into
// the line only if it is already resident). The pipeline is stalled via
// cache_miss_o until the memory acknowledges.
module data_cache_controller
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int SETS       = NUM_SETS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemRead_i,
  input  logic                  MemWrite_i,
  input  logic [ADDR_WIDTH-1:0] Addr_i,
  input  logic [DATA_WIDTH-1:0] WriteData_i,
  input  logic [3:0]            ByteEn_i,
  output logic [DATA_WIDTH-1:0] ReadData_o,
  output logic                  cache_miss_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_be_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TG_W  = ADDR_WIDTH - 2 - IDX_W;

  state_t state, next_state;

  logic [IDX_W-1:0]      req_idx, pend_idx, rd_idx;
  logic [TG_W-1:0]       req_tag, pend_tag;
  logic                  req_hit, pend_hit;
  line_t                 line;
  logic                  wr_fill, wr_merge;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  unused_addr_bits;

  // The incoming request selects the line while idle; during a transaction the
  // registered memory address does, so a dropped request cannot redirect it.
  assign req_idx  = Addr_i[2 +: IDX_W];
  assign req_tag  = Addr_i[ADDR_WIDTH-1 -: TG_W];
  assign pend_idx = mem_addr_o[2 +: IDX_W];
  assign pend_tag = mem_addr_o[ADDR_WIDTH-1 -: TG_W];
  assign rd_idx   = (state == IDLE) ? req_idx : pend_idx;
  assign req_hit  = line.valid && (line.tag == req_tag);
  assign pend_hit = line.valid && (line.tag == pend_tag);

  assign unused_addr_bits = ^Addr_i[1:0];

  cache_data_array u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (rd_idx),
    .rd_line  (line),
    .wr_idx   (pend_idx),
    .wr_fill  (wr_fill),
    .wr_merge (wr_merge),
    .wr_tag   (pend_tag),
    .wr_data  (wr_data),
    .wr_be    (mem_be_o)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: stores always go to memory, loads only on a miss
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (MemWrite_i) begin
          next_state = WRITE;
        end else if (MemRead_i && !req_hit) begin
          next_state = FILL;
        end
      end
      FILL, WRITE: begin
        if (mem_ack_i) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs: stall and load data to the pipeline, write strobes to the array
  always_comb begin
    cache_miss_o = 1'b0;
    ReadData_o   = line.data;
    wr_fill      = 1'b0;
    wr_merge     = 1'b0;
    wr_data      = mem_wdata_o;
    case (state)
      IDLE: begin
        if (MemWrite_i) begin
          cache_miss_o = 1'b1;
        end else if (MemRead_i && !req_hit) begin
          cache_miss_o = 1'b1;
        end
      end
      FILL: begin
        cache_miss_o = !mem_ack_i;
        wr_data      = mem_rdata_i;
        if (mem_ack_i) begin
          ReadData_o = mem_rdata_i;
          wr_fill    = 1'b1;
        end
      end
      WRITE: begin
        cache_miss_o = !mem_ack_i;
        wr_merge     = mem_ack_i && pend_hit;
      end
      default: begin
        cache_miss_o = 1'b0;
      end
    endcase
  end

  // Memory request registers: loaded when a transaction starts, held until ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
    end else if (state == IDLE && next_state != IDLE) begin
      mem_req_o   <= 1'b1;
      mem_we_o    <= (next_state == WRITE);
      mem_addr_o  <= {Addr_i[ADDR_WIDTH-1:2], 2'b00};
      mem_wdata_o <= (next_state == WRITE) ? WriteData_i : '0;
      mem_be_o    <= (next_state == WRITE) ? ByteEn_i : 4'b0000;
    end else if (state != IDLE && next_state == IDLE) begin
      mem_req_o <= 1'b0;
      mem_we_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_cache_controller.sv
// Scoreboard bench for data_cache_controller. The driver predicts each
// request's outcome from a set-residency table plus a word-addressed memory
// model, queues the expected pipeline response and memory transaction, and a
// monitor / memory responder compare what the DUT presents.
module tb_data_cache_controller;

  logic        clk;
  logic        rst_n;
  logic        MemRead_i, MemWrite_i;
  logic [31:0] Addr_i, WriteData_i;
  logic [3:0]  ByteEn_i;
  logic [31:0] ReadData_o;
  logic        cache_miss_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    int          stall;
  } resp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } memtx_t;

  resp_t  exp_resp[$];
  memtx_t exp_mem[$];
  int     delay_q[$];

  logic [31:0] mem_model [int unsigned];
  int          resident [256];

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int txn_cnt  = 0;
  int stall_cnt = 0;

  data_cache_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .MemRead_i    (MemRead_i),
    .MemWrite_i   (MemWrite_i),
    .Addr_i       (Addr_i),
    .WriteData_i  (WriteData_i),
    .ByteEn_i     (ByteEn_i),
    .ReadData_o   (ReadData_o),
    .cache_miss_o (cache_miss_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_be_o     (mem_be_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word contents of main memory; untouched words hold an address-derived pattern
  function automatic logic [31:0] mem_word(input int unsigned waddr);
    if (mem_model.exists(waddr)) return mem_model[waddr];
    return (waddr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Issue one load/store, predict its outcome and wait for the monitor to see it complete
  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be, input int d);
    int unsigned waddr;
    int          set;
    int          t0, d0, exp_tx;
    bit          done;
    resp_t       r;
    memtx_t      m;
    waddr = addr >> 2;
    set   = int'(waddr % 256);
    m.we = wr; m.addr = {addr[31:2], 2'b00}; m.wdata = wdata; m.be = be;
    if (wr) begin
      r.is_read = 1'b0; r.data = '0; r.stall = 1 + d;
      exp_mem.push_back(m); delay_q.push_back(d);
      exp_tx = 1;
    end else if (resident[set] == int'(waddr)) begin
      r.is_read = 1'b1; r.data = mem_word(waddr); r.stall = 0;
      exp_tx = 0;
    end else begin
      r.is_read = 1'b1; r.data = mem_word(waddr); r.stall = 1 + d;
      exp_mem.push_back(m); delay_q.push_back(d);
      resident[set] = int'(waddr);
      exp_tx = 1;
    end
    exp_resp.push_back(r);
    MemRead_i = rd; MemWrite_i = wr; Addr_i = addr; WriteData_i = wdata; ByteEn_i = be;
    t0 = txn_cnt; d0 = done_cnt; done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      if (done_cnt != d0) begin
        done = 1'b1;
        break;
      end
    end
    #1;
    MemRead_i = 1'b0; MemWrite_i = 1'b0; Addr_i = $urandom; WriteData_i = $urandom; ByteEn_i = 4'($urandom);
    if (!done) begin
      n_tests++; n_fail++;
      $display("[TB] FAIL request_timeout: addr 0x%08h not completed, expected completion within 100 cycles", addr);
      exp_resp.delete(); exp_mem.delete(); delay_q.delete();
    end else begin
      checkOutput("txn_count", txn_cnt - t0, exp_tx);
    end
  endtask

  // Pipeline-side monitor: a request completes on the first cycle with no stall
  always @(negedge clk) begin
    resp_t r;
    if (!rst_n || !(MemRead_i || MemWrite_i)) begin
      stall_cnt = 0;
    end else if (cache_miss_o) begin
      stall_cnt++;
    end else begin
      if (exp_resp.size() == 0) begin
        n_tests++; n_fail++;
        $display("[TB] FAIL unexpected_completion: got completion for 0x%08h, expected none", Addr_i);
      end else begin
        r = exp_resp.pop_front();
        checkOutput("stall_cycles", stall_cnt, r.stall);
        if (r.is_read) checkOutput("read_data", ReadData_o, r.data);
      end
      stall_cnt = 0;
      done_cnt++;
    end
  end

  // Memory responder: checks each new request, holds it for the queued delay, then acks
  initial begin
    memtx_t      m;
    logic        c_we;
    logic [31:0] c_addr, c_wdata, old;
    logic [3:0]  c_be;
    logic [31:0] mask;
    int          d;
    bit          aborted, stable;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && mem_req_o) begin
        txn_cnt++;
        c_we = mem_we_o; c_addr = mem_addr_o; c_wdata = mem_wdata_o; c_be = mem_be_o;
        if (exp_mem.size() == 0) begin
          n_tests++; n_fail++;
          $display("[TB] FAIL unexpected_mem_req: got addr 0x%08h we %0b, expected no request", c_addr, c_we);
        end else begin
          m = exp_mem.pop_front();
          checkOutput("mem_we", c_we, m.we);
          checkOutput("mem_addr", c_addr, m.addr);
          if (m.we) begin
            checkOutput("mem_wdata", c_wdata, m.wdata);
            checkOutput("mem_be", c_be, m.be);
          end
        end
        d = (delay_q.size() != 0) ? delay_q.pop_front() : 0;
        aborted = 1'b0; stable = 1'b1;
        for (int k = 0; k < d; k++) begin
          @(posedge clk); #1;
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          if (mem_req_o !== 1'b1 || mem_we_o !== c_we || mem_addr_o !== c_addr ||
              mem_wdata_o !== c_wdata || mem_be_o !== c_be) stable = 1'b0;
        end
        if (!aborted) begin
          checkOutput("mem_hold_stable", stable, 1'b1);
          mem_ack_i = 1'b1;
          if (c_we) begin
            mask = {{8{c_be[3]}}, {8{c_be[2]}}, {8{c_be[1]}}, {8{c_be[0]}}};
            old = mem_word(c_addr >> 2);
            mem_model[c_addr >> 2] = (old & ~mask) | (c_wdata & mask);
            mem_rdata_i = $urandom;
          end else begin
            mem_rdata_i = mem_word(c_addr >> 2);
          end
          @(posedge clk); #1;
          mem_ack_i = 1'b0;
          mem_rdata_i = $urandom;
        end
      end
    end
  end

  // Global time limit so the run always ends
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    bit           got;
    int unsigned  ra, rtag, ridx;
    bit           rd, wr;
    rst_n = 1'b0;
    MemRead_i = 1'b0; MemWrite_i = 1'b0; Addr_i = '0; WriteData_i = '0; ByteEn_i = '0;
    foreach (resident[i]) resident[i] = -1;
    mem_model[32'h100 >> 2] = 32'hDEAD_BEEF;
    mem_model[32'h500 >> 2] = 32'hCAFE_F00D;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_mem_req", mem_req_o, 1'b0);
    checkOutput("reset_mem_we", mem_we_o, 1'b0);
    checkOutput("reset_mem_addr", mem_addr_o, 32'h0);
    checkOutput("reset_mem_wdata", mem_wdata_o, 32'h0);
    checkOutput("reset_mem_be", mem_be_o, 4'h0);
    checkOutput("reset_cache_miss", cache_miss_o, 1'b0);
    @(posedge clk); #1;

    $display("[TB] read miss, fill, then hit");
    applyStimulus(1, 0, 32'h100, 32'h0, 4'h0, 1);
    applyStimulus(1, 0, 32'h100, 32'h0, 4'h0, 0);

    $display("[TB] conflict eviction");
    applyStimulus(1, 0, 32'h500, 32'h0, 4'h0, 2);
    applyStimulus(1, 0, 32'h100, 32'h0, 4'h0, 0);

    $display("[TB] write-through hit with byte merge");
    applyStimulus(0, 1, 32'h100, 32'h1234_5678, 4'b0011, 1);
    applyStimulus(1, 0, 32'h100, 32'h0, 4'h0, 0);
    checkOutput("merged_word_model", mem_word(32'h100 >> 2), 32'hDEAD_5678);

    $display("[TB] write miss without allocate");
    applyStimulus(0, 1, 32'h800, 32'hA5A5_5A5A, 4'b1111, 0);
    applyStimulus(1, 0, 32'h800, 32'h0, 4'h0, 1);

    $display("[TB] reset during fill");
    exp_mem.push_back('{we: 1'b0, addr: 32'h904, wdata: 32'h0, be: 4'h0});
    delay_q.push_back(20);
    MemRead_i = 1'b1; Addr_i = 32'h904;
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (mem_req_o) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("fill_started", got, 1'b1);
    @(negedge clk);
    rst_n = 1'b0; MemRead_i = 1'b0;
    #1;
    checkOutput("mem_req_async_drop", mem_req_o, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    foreach (resident[i]) resident[i] = -1;
    @(posedge clk); #1;
    applyStimulus(1, 0, 32'h100, 32'h0, 4'h0, 0);

    $display("[TB] long ack delay");
    applyStimulus(1, 0, 32'hA00, 32'h0, 4'h0, 10);

    $display("[TB] request dropped mid-fill");
    exp_mem.push_back('{we: 1'b0, addr: 32'hC04, wdata: 32'h0, be: 4'h0});
    delay_q.push_back(3);
    MemRead_i = 1'b1; Addr_i = 32'hC04;
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (mem_req_o) begin
        got = 1'b1;
        break;
      end
    end
    MemRead_i = 1'b0;
    checkOutput("flush_fill_started", got, 1'b1);
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (!mem_req_o) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("flush_fill_finished", got, 1'b1);
    resident[(32'hC04 >> 2) % 256] = int'(32'hC04 >> 2);
    applyStimulus(1, 0, 32'hC04, 32'h0, 4'h0, 0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 200; n++) begin
      rtag = $urandom_range(0, 3);
      ridx = $urandom_range(0, 7);
      ra   = (rtag << 10) | (ridx << 2) | $urandom_range(0, 3);
      rd   = ($urandom_range(0, 99) < 65);
      wr   = !rd || ($urandom_range(0, 9) == 0);
      applyStimulus(rd, wr, ra, $urandom, 4'($urandom), $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    checkOutput("leftover_responses", exp_resp.size(), 0);
    checkOutput("leftover_mem_txns", exp_mem.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
